// File: rtl/product_bcd_converter.sv
// Signed product to sign + packed BCD magnitude converter.
// Sequential shift-add-3 (double dabble): one ADJUST and one SHIFT cycle per
// product bit. The result registers only load on the final shift, so the
// outputs always show the last completed conversion.
module product_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [WIDTH-1:0]      Product,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Sign,
   output logic [4*DIGITS-1:0]   Bcd
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int BW = 4 * DIGITS;

   typedef enum logic [2:0] {IDLE, LOAD, ADJUST, SHIFT, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] product_q;
   logic [WIDTH-1:0] magnitude;
   logic [BW-1:0]    scratch;
   logic [BW-1:0]    scratch_adj;
   logic [BW-1:0]    scratch_shl;
   logic             sign_pend;
   logic [CW-1:0]    count;
   logic             last_shift;

   assign last_shift  = (count == CW'(WIDTH - 1));
   assign scratch_shl = {scratch[BW-2:0], magnitude[WIDTH-1]};

   // Add 3 to every digit that is 5 or more; digits are independent (no carry)
   always_comb begin
      scratch_adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5)
            scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
   end

   // State register
   always_ff @(posedge Clk) begin
      if (!Reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state and status decode
   always_comb begin
      state_next = state;
      Busy       = 1'b0;
      Done       = 1'b0;
      case (state)
         IDLE:    if (Start) state_next = LOAD;
         LOAD:    begin Busy = 1'b1; state_next = ADJUST; end
         ADJUST:  begin Busy = 1'b1; state_next = SHIFT; end
         SHIFT:   begin
                     Busy       = 1'b1;
                     state_next = last_shift ? DONE : ADJUST;
                  end
         DONE:    begin Done = 1'b1; state_next = IDLE; end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: input capture, magnitude/scratch iteration, result load
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         product_q <= '0;
         magnitude <= '0;
         scratch   <= '0;
         sign_pend <= 1'b0;
         count     <= '0;
         Bcd       <= '0;
         Sign      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) product_q <= Product;
            end
            LOAD: begin
               // Most negative value wraps to itself, which read unsigned is 2^(WIDTH-1)
               magnitude <= product_q[WIDTH-1] ? (~product_q + WIDTH'(1)) : product_q;
               sign_pend <= product_q[WIDTH-1];
               scratch   <= '0;
               count     <= '0;
            end
            ADJUST: begin
               scratch <= scratch_adj;
            end
            SHIFT: begin
               scratch   <= scratch_shl;
               magnitude <= {magnitude[WIDTH-2:0], 1'b0};
               count     <= count + CW'(1);
               if (last_shift) begin
                  Bcd  <= scratch_shl;
                  Sign <= sign_pend;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
